// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, program ROM and the datapath selectors.
interface fetch_sequencer_if #(
  parameter int unsigned N = 4
);
  logic         run;
  logic [7:0]   instr;
  logic         instr_valid;
  logic         zed;
  logic [N-1:0] addr;
  logic         fetch_req;
  logic         scratch_we;
  logic         sys_we;
  logic         in_re;
  logic [2:0]   sel;
  logic         halted;
  logic         busy;

  modport master (
    input  run, instr, instr_valid, zed,
    output addr, fetch_req, scratch_we, sys_we, in_re, sel, halted, busy
  );

  modport slave (
    output run, instr, instr_valid, zed,
    input  addr, fetch_req, scratch_we, sys_we, in_re, sel, halted, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches from ROM and issues one-cycle
// selector strobes in EXEC. Every output decodes from registered state only.
module fetch_sequencer #(
  parameter int unsigned N = 4
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StHalt   = 3'd4;

  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpJmp   = 4'h3;
  localparam logic [3:0] OpJz    = 4'h4;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam logic [N-1:0] PcOne = N'(1);

  logic [2:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [7:0]   instr_q, instr_d;

  logic [3:0]   opcode;
  logic         in_exec;

  assign opcode  = instr_q[7:4];
  assign in_exec = (state_q == StExec);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = bus.run ? StFetch : StIdle;
        case (opcode)
          OpJmp:   pc_d = instr_q[N-1:0];
          OpJz:    pc_d = bus.zed ? instr_q[N-1:0] : pc_q + PcOne;
          OpHalt:  state_d = StHalt;
          default: pc_d = pc_q + PcOne;
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Strobes are gated by EXEC so an async reset mid-EXEC removes them at once.
  always_comb begin
    bus.addr       = pc_q;
    bus.sel        = instr_q[2:0];
    bus.fetch_req  = (state_q == StFetch);
    bus.busy       = (state_q == StFetch) || (state_q == StDecode) || in_exec;
    bus.halted     = (state_q == StHalt);
    bus.in_re      = in_exec && (opcode == OpLoad);
    bus.scratch_we = in_exec && (opcode == OpStore) && instr_q[3];
    bus.sys_we     = in_exec && (opcode == OpStore) && !instr_q[3];
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one N=4 and one N=2 instance share control inputs,
// each fetches from its own ROM array.
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  logic run;
  logic instr_valid;
  logic zed;

  logic [7:0] rom  [16];
  logic [7:0] rom2 [4];

  int n_checks;
  int n_fail;

  fetch_sequencer_if #(.N(4)) bus  ();
  fetch_sequencer_if #(.N(2)) bus2 ();

  assign bus.run          = run;
  assign bus.instr_valid  = instr_valid;
  assign bus.zed          = zed;
  assign bus.instr        = rom[bus.addr];
  assign bus2.run         = run;
  assign bus2.instr_valid = instr_valid;
  assign bus2.zed         = zed;
  assign bus2.instr       = rom2[bus2.addr];

  fetch_sequencer #(.N(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_sequencer #(.N(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves reset released 1 time unit after a rising edge; DUTs sit in IDLE.
  task automatic reset_dut();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  function automatic logic [2:0] strobes();
    return {bus.scratch_we, bus.sys_we, bus.in_re};
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    run = 1'b0;
    instr_valid = 1'b0;
    zed = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom2[0] = 8'h33;
    rom2[1] = 8'h00;
    rom2[2] = 8'h30;
    rom2[3] = 8'h00;

    // Reset values before any clock edge
    #1;
    check("rst_addr", 32'(bus.addr), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_fetch_req", 32'(bus.fetch_req), 32'h0);
    check("rst_strobes", 32'(strobes()), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // STORE scratch then STORE sys, back to back
    rom[0] = 8'h2B;
    rom[1] = 8'h23;
    step(1);
    rst = 1'b0;
    run = 1'b1;
    instr_valid = 1'b1;
    step(1);
    check("t1_fetch_req", 32'(bus.fetch_req), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'h1);
    check("t1_addr0", 32'(bus.addr), 32'h0);
    step(1);
    check("t1_decode_fetch_req", 32'(bus.fetch_req), 32'h0);
    check("t1_decode_strobes", 32'(strobes()), 32'h0);
    step(1);
    check("t1_exec0_strobes", 32'(strobes()), 32'b100);
    check("t1_exec0_sel", 32'(bus.sel), 32'h3);
    check("t1_exec0_addr", 32'(bus.addr), 32'h0);
    step(1);
    check("t1_fetch1_addr", 32'(bus.addr), 32'h1);
    check("t1_fetch1_strobes", 32'(strobes()), 32'h0);
    step(2);
    check("t1_exec1_strobes", 32'(strobes()), 32'b010);
    check("t1_exec1_sel", 32'(bus.sel), 32'h3);
    check("t1_exec1_addr", 32'(bus.addr), 32'h1);
    step(1);
    check("t1_addr2", 32'(bus.addr), 32'h2);
    check("t1_fetch2_req", 32'(bus.fetch_req), 32'h1);

    // FETCH stall: four cycles with instr_valid low
    rom[0] = 8'h13;
    instr_valid = 1'b0;
    reset_dut();
    step(1);
    for (int i = 0; i < 4; i++) begin
      check("t2_stall_req", 32'(bus.fetch_req), 32'h1);
      check("t2_stall_strobes", 32'(strobes()), 32'h0);
      check("t2_stall_addr", 32'(bus.addr), 32'h0);
      step(1);
    end
    check("t2_fifth_req", 32'(bus.fetch_req), 32'h1);
    instr_valid = 1'b1;
    step(1);
    check("t2_decode_req", 32'(bus.fetch_req), 32'h0);
    rom[0] = 8'h2F;  // must not be latched outside FETCH
    step(1);
    check("t2_exec_strobes", 32'(strobes()), 32'b001);
    check("t2_exec_sel", 32'(bus.sel), 32'h3);
    step(1);
    check("t2_addr1", 32'(bus.addr), 32'h1);

    // N=2 instance: jump to 3, wrap to 0, then JZ taken and not taken
    reset_dut();
    step(3);
    step(1);
    check("t3_jmp_addr", 32'(bus2.addr), 32'h3);
    rom2[0] = 8'h42;
    step(3);
    check("t3_wrap_addr", 32'(bus2.addr), 32'h0);
    step(2);
    zed = 1'b1;
    step(1);
    check("t3_jz_taken", 32'(bus2.addr), 32'h2);
    zed = 1'b0;
    step(3);
    check("t3_back_to0", 32'(bus2.addr), 32'h0);
    zed = 1'b1;  // zed high in FETCH/DECODE, low at the EXEC sample
    step(2);
    zed = 1'b0;
    step(1);
    check("t3_jz_not_taken", 32'(bus2.addr), 32'h1);

    // run dropped during DECODE of LOAD
    rom[0] = 8'h15;
    rom[1] = 8'h00;
    reset_dut();
    step(2);
    run = 1'b0;
    step(1);
    check("t4_exec_strobes", 32'(strobes()), 32'b001);
    check("t4_exec_sel", 32'(bus.sel), 32'h5);
    step(1);
    check("t4_idle_busy", 32'(bus.busy), 32'h0);
    check("t4_idle_addr", 32'(bus.addr), 32'h1);
    check("t4_idle_strobes", 32'(strobes()), 32'h0);
    step(2);
    check("t4_still_idle", 32'(bus.busy), 32'h0);
    check("t4_still_req", 32'(bus.fetch_req), 32'h0);
    run = 1'b1;
    step(1);
    check("t4_resume_req", 32'(bus.fetch_req), 32'h1);
    check("t4_resume_addr", 32'(bus.addr), 32'h1);

    // HALT is sticky until reset
    rom[0] = 8'hF0;
    reset_dut();
    step(3);
    check("t5_exec_strobes", 32'(strobes()), 32'h0);
    step(1);
    check("t5_halted", 32'(bus.halted), 32'h1);
    check("t5_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      step(1);
      check("t5_hold_halted", 32'(bus.halted), 32'h1);
      check("t5_hold_strobes", 32'(strobes()), 32'h0);
      check("t5_hold_addr", 32'(bus.addr), 32'h0);
    end
    run = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_halted", 32'(bus.halted), 32'h0);
    step(1);
    rst = 1'b0;
    step(1);
    check("t5_idle_busy", 32'(bus.busy), 32'h0);
    check("t5_idle_halted", 32'(bus.halted), 32'h0);

    // Async reset in the middle of an EXEC cycle
    rom[0] = 8'h00;
    rom[1] = 8'h2B;
    run = 1'b1;
    reset_dut();
    step(6);
    check("t6_exec_strobes", 32'(strobes()), 32'b100);
    check("t6_exec_addr", 32'(bus.addr), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_strobes", 32'(strobes()), 32'h0);
    check("t6_async_addr", 32'(bus.addr), 32'h0);
    check("t6_async_sel", 32'(bus.sel), 32'h0);
    check("t6_async_busy", 32'(bus.busy), 32'h0);
    check("t6_async_req", 32'(bus.fetch_req), 32'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
